// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one digit lit at a time, with new
// frames staged and swapped in only at frame boundaries so no torn values appear.
module seg_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_in,
  input  logic                  lz_supp,
  output logic [4:0]            dec_data,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [4:0] BLANK_CODE = 5'b01111;

  logic [CW-1:0]          div_cnt_q, div_cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    act_digits_q, act_digits_d, stg_digits_q, stg_digits_d;
  logic [DIGITS-1:0]      act_dp_q, act_dp_d, stg_dp_q, stg_dp_d;
  logic [DIGITS-1:0]      act_en_q, act_en_d, stg_en_q, stg_en_d;
  logic                   pending_q, pending_d;
  logic [4:0]             dec_q, dec_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   frame_done_q;

  logic tc;
  logic boundary;

  assign tc       = (div_cnt_q == CW'(REFRESH_DIV - 1));
  assign boundary = tc && (idx_q == IW'(DIGITS - 1));

  // Divider, digit index and frame staging/commit.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    div_cnt_d    = tc ? '0 : div_cnt_q + 1'b1;
    idx_d        = idx_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_en_d     = stg_en_q;
    pending_d    = pending_q;

    if (tc) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    if (load) begin
      stg_digits_d = digits_in;
      stg_dp_d     = dp_in;
      stg_en_d     = en_in;
      pending_d    = 1'b1;
    end

    if (boundary) begin
      // A load landing on the boundary bypasses staging and commits directly.
      if (load) begin
        act_digits_d = digits_in;
        act_dp_d     = dp_in;
        act_en_d     = en_in;
      end else if (pending_q) begin
        act_digits_d = stg_digits_q;
        act_dp_d     = stg_dp_q;
        act_en_d     = stg_en_q;
      end
      pending_d = 1'b0;
    end
  end

  // Output selection, including leading-zero suppression of the current digit.
  logic       all_zero;
  logic       suppress;
  logic [3:0] cur_bcd;
  always_comb begin
    all_zero = 1'b1;
    suppress = 1'b0;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      all_zero = all_zero & act_en_q[j] & ~act_dp_q[j] & (act_digits_q[4*j +: 4] == 4'd0);
      if (IW'(j) == idx_q) suppress = all_zero;
    end
    cur_bcd = act_digits_q[{idx_q, 2'b00} +: 4];

    an_d  = '1;
    dec_d = BLANK_CODE;
    if (act_en_q[idx_q] && !(lz_supp && (idx_q != '0) && suppress)) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      dec_d = {act_dp_q[idx_q], cur_bcd};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      stg_digits_q <= '0;
      stg_dp_q     <= '0;
      stg_en_q     <= '0;
      pending_q    <= 1'b0;
      dec_q        <= BLANK_CODE;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      stg_digits_q <= stg_digits_d;
      stg_dp_q     <= stg_dp_d;
      stg_en_q     <= stg_en_d;
      pending_q    <= pending_d;
      dec_q        <= dec_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign dec_data   = dec_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [4:0] BLANK  = 5'b01111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic        lz_supp;
  logic [4:0]  dec_data;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .lz_supp    (lz_supp),
    .dec_data   (dec_data),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Waits (bounded) for a frame_done pulse, sampled on falling edges.
  task automatic wait_frame(input int exp_cnt);
    int cnt = 0;
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    if (exp_cnt > 0) check("frame_period", cnt, exp_cnt);
  endtask

  // Checks one full frame starting right after a frame_done sample; optionally
  // issues up to two loads at the given cycle offsets within the frame.
  task automatic run_frame(input string name,
                           input logic [3:0][3:0] an_e, input logic [3:0][4:0] dec_e,
                           input logic lz,
                           input int la, input logic [15:0] da,
                           input int lb, input logic [15:0] db,
                           input logic [3:0] dp_l, input logic [3:0] en_l);
    lz_supp = lz;
    for (int n = 1; n <= 16; n++) begin
      int d;
      @(negedge clk);
      d = (n - 1) / 4;
      check($sformatf("%s_an_d%0d_n%0d", name, d, n), 32'(an), 32'(an_e[d]));
      check($sformatf("%s_dec_d%0d_n%0d", name, d, n), 32'(dec_data), 32'(dec_e[d]));
      check($sformatf("%s_fd_n%0d", name, n), 32'(frame_done), 32'(n == 16));
      load = 1'b0;
      if (n == la) begin load = 1'b1; digits_in = da; dp_in = dp_l; en_in = en_l; end
      if (n == lb) begin load = 1'b1; digits_in = db; dp_in = dp_l; en_in = en_l; end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; en_in = '0; lz_supp = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'(AN_OFF));
    check("rst_dec", 32'(dec_data), 32'(BLANK));
    check("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Blank display after reset; load 1234 mid-frame, old (blank) frame must persist.
    wait_frame(16);
    run_frame("blank0", {AN_OFF, AN_OFF, AN_OFF, AN_OFF}, {BLANK, BLANK, BLANK, BLANK},
              1'b0, 6, 16'h1234, 0, 16'h0, 4'b0100, 4'b1111);

    // 1234 with dp on digit 2; stage 0050 for the suppression tests.
    run_frame("f1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {5'h01, 5'h12, 5'h03, 5'h04},
              1'b0, 5, 16'h0050, 0, 16'h0, 4'b0000, 4'b1111);

    // Leading zeros suppressed on digits 3 and 2.
    run_frame("lz_on", {AN_OFF, AN_OFF, 4'b1101, 4'b1110}, {BLANK, BLANK, 5'h05, 5'h00},
              1'b1, 0, 16'h0, 0, 16'h0, 4'b0000, 4'b1111);

    // Same frame without suppression; two loads in this frame, last one wins.
    run_frame("lz_off", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {5'h00, 5'h00, 5'h05, 5'h00},
              1'b0, 3, 16'h1111, 9, 16'h2222, 4'b0000, 4'b1111);

    // Only 2222 shown; load on the boundary cycle (n=15 -> captured at boundary edge).
    run_frame("f2222", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {5'h02, 5'h02, 5'h02, 5'h02},
              1'b0, 15, 16'h9999, 0, 16'h0, 4'b0000, 4'b1010);

    // Enable mask 1010 blanks digits 0 and 2.
    run_frame("en1010", {4'b0111, AN_OFF, 4'b1101, AN_OFF}, {5'h09, BLANK, 5'h09, BLANK},
              1'b0, 0, 16'h0, 0, 16'h0, 4'b0000, 4'b1010);

    // Stage a frame, then reset mid-digit: outputs reset asynchronously, frame lost.
    @(negedge clk);
    @(negedge clk);
    load = 1'b1; digits_in = 16'h8888; dp_in = 4'b0000; en_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_an", 32'(an), 32'(4'b1101));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'(AN_OFF));
    check("async_rst_dec", 32'(dec_data), 32'(BLANK));
    check("async_rst_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame(16);
    run_frame("post_rst", {AN_OFF, AN_OFF, AN_OFF, AN_OFF}, {BLANK, BLANK, BLANK, BLANK},
              1'b1, 4, 16'hA0F3, 0, 16'h0, 4'b1001, 4'b1111);

    // Non-decimal codes pass through; an inner zero below a nonzero digit stays lit.
    run_frame("hexdp", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {5'h1A, 5'h00, 5'h0F, 5'h13},
              1'b1, 0, 16'h0, 0, 16'h0, 4'b0000, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
